// File: rtl/sram_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encodings, watchdog width and bus widths.
// No logic, so no latency or backpressure of its own.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef REGISTER_LEN
`define REGISTER_LEN 32
`endif

package sram_arbiter_pkg;
   localparam int ADDR_W        = `ADDRESS_LEN;
   localparam int DATA_W        = `REGISTER_LEN;
   localparam int ARB_TIMEOUT_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT0 = 2'd1,
      ARB_GRANT1 = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } arb_req_t;

   // Both enables asserted together means a write.
   function automatic arb_req_t mk_req(input logic re, input logic we,
                                       input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] wdata);
      arb_req_t r;
      r.wr    = we;
      r.rd    = re & ~we;
      r.addr  = addr;
      r.wdata = wdata;
      return r;
   endfunction
endpackage

// File: rtl/sram_arb_picker.sv
// Combinational tie-break between two requesters; one-hot pick, zero latency, no backpressure.
// ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise port 0 has fixed priority.
module sram_arb_picker (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] pick
);
`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      pick = 2'b00;
      if (req == 2'b11) begin
         pick = last_grant ? 2'b01 : 2'b10;
      end else begin
         pick = req;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      pick = 2'b00;
      if (req[0]) begin
         pick = 2'b01;
      end else if (req[1]) begin
         pick = 2'b10;
      end
   end
`endif
endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the SRAM controller; ctrl_* registered one cycle after the grant decision,
// losing/pending port held with ready low until completion or watchdog expiry (tie-break: ARB_ROUND_ROBIN_EN).
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_read_enable,
   input  logic              req0_write_enable,
   input  logic [ADDR_W-1:0] req0_address,
   input  logic [DATA_W-1:0] req0_write_data,
   output logic [DATA_W-1:0] req0_read_data,
   output logic              req0_ready,
   input  logic              req1_read_enable,
   input  logic              req1_write_enable,
   input  logic [ADDR_W-1:0] req1_address,
   input  logic [DATA_W-1:0] req1_write_data,
   output logic [DATA_W-1:0] req1_read_data,
   output logic              req1_ready,
   output logic              ctrl_read_enable,
   output logic              ctrl_write_enable,
   output logic [ADDR_W-1:0] ctrl_address,
   output logic [DATA_W-1:0] ctrl_write_data,
   input  logic [DATA_W-1:0] ctrl_read_data,
   input  logic              ctrl_ready,
   output logic              grant,
   output logic              err_timeout
);
   localparam logic [ARB_TIMEOUT_W-1:0] TMO_LIM = ARB_TIMEOUT_W'(TIMEOUT_CYCLES);

   arb_state_t               state, state_nxt;
   arb_req_t                 cur_q;
   logic                     grant_q, last_q, err_q;
   logic [ARB_TIMEOUT_W-1:0] wdog_q;
   logic [DATA_W-1:0]        hold0_q, hold1_q;
   logic                     req0, req1;
   logic [1:0]               pick;
   logic                     in_grant, tmo, done, done0, done1;
   logic [DATA_W-1:0]        done_data;

   assign req0 = req0_read_enable | req0_write_enable;
   assign req1 = req1_read_enable | req1_write_enable;

   sram_arb_picker u_picker (
      .req        ({req1, req0}),
      .last_grant (last_q),
      .pick       (pick)
   );

   // A real completion wins over a watchdog expiry in the same cycle.
   assign in_grant  = (state != ARB_IDLE);
   assign tmo       = in_grant && !ctrl_ready && (wdog_q == TMO_LIM);
   assign done      = in_grant && (ctrl_ready || tmo);
   assign done0     = done && (state == ARB_GRANT0);
   assign done1     = done && (state == ARB_GRANT1);
   assign done_data = ctrl_ready ? ctrl_read_data : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (pick[0]) begin
               state_nxt = ARB_GRANT0;
            end else if (pick[1]) begin
               state_nxt = ARB_GRANT1;
            end
         end
         ARB_GRANT0, ARB_GRANT1: begin
            if (done) begin
               state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_q   <= '0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         wdog_q  <= '0;
         err_q   <= 1'b0;
         hold0_q <= '0;
         hold1_q <= '0;
      end else begin
         if (state == ARB_IDLE && state_nxt == ARB_GRANT0) begin
            cur_q   <= mk_req(req0_read_enable, req0_write_enable, req0_address, req0_write_data);
            grant_q <= 1'b0;
            last_q  <= 1'b0;
            wdog_q  <= '0;
         end else if (state == ARB_IDLE && state_nxt == ARB_GRANT1) begin
            cur_q   <= mk_req(req1_read_enable, req1_write_enable, req1_address, req1_write_data);
            grant_q <= 1'b1;
            last_q  <= 1'b1;
            wdog_q  <= '0;
         end else if (in_grant) begin
            if (done) begin
               cur_q.rd <= 1'b0;
               cur_q.wr <= 1'b0;
            end else begin
               wdog_q <= wdog_q + 1'b1;
            end
         end
         if (tmo) begin
            err_q <= 1'b1;
         end
         // A withdrawn request still completes, but its data is not kept.
         if (done0 && cur_q.rd && req0) begin
            hold0_q <= done_data;
         end
         if (done1 && cur_q.rd && req1) begin
            hold1_q <= done_data;
         end
      end
   end

   assign ctrl_read_enable  = cur_q.rd;
   assign ctrl_write_enable = cur_q.wr;
   assign ctrl_address      = cur_q.addr;
   assign ctrl_write_data   = cur_q.wdata;

   assign req0_ready     = !req0 || done0;
   assign req1_ready     = !req1 || done1;
   assign req0_read_data = done0 ? done_data : hold0_q;
   assign req1_read_data = done1 ? done_data : hold1_q;

   assign grant       = grant_q;
   assign err_timeout = err_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed accesses against a latency-programmable controller model.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        p_re, p_we;
   logic [ADDR_W-1:0] p_addr [2];
   logic [DATA_W-1:0] p_wd [2];
   logic [DATA_W-1:0] req0_read_data, req1_read_data;
   logic              req0_ready, req1_ready;
   logic              ctrl_read_enable, ctrl_write_enable;
   logic [ADDR_W-1:0] ctrl_address;
   logic [DATA_W-1:0] ctrl_write_data;
   logic [DATA_W-1:0] ctrl_read_data;
   logic              ctrl_ready;
   logic              grant, err_timeout;

   always #5 clk = ~clk;

   sram_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .req0_read_enable  (p_re[0]),
      .req0_write_enable (p_we[0]),
      .req0_address      (p_addr[0]),
      .req0_write_data   (p_wd[0]),
      .req0_read_data    (req0_read_data),
      .req0_ready        (req0_ready),
      .req1_read_enable  (p_re[1]),
      .req1_write_enable (p_we[1]),
      .req1_address      (p_addr[1]),
      .req1_write_data   (p_wd[1]),
      .req1_read_data    (req1_read_data),
      .req1_ready        (req1_ready),
      .ctrl_read_enable  (ctrl_read_enable),
      .ctrl_write_enable (ctrl_write_enable),
      .ctrl_address      (ctrl_address),
      .ctrl_write_data   (ctrl_write_data),
      .ctrl_read_data    (ctrl_read_data),
      .ctrl_ready        (ctrl_ready),
      .grant             (grant),
      .err_timeout       (err_timeout)
   );

   typedef struct {
      int                port;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rdata;
      bit                is_read;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt [2] = '{0, 0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Controller model: ctrl_lat low cycles, then one completion cycle.
   int                ctrl_lat = 0;
   int                busy = 0;
   bit                ovr_en = 0;
   logic [DATA_W-1:0] ovr_dat = '0;

   initial begin
      ctrl_ready     = 1'b0;
      ctrl_read_data = 32'h1234_5678;
      forever begin
         @(posedge clk);
         #1;
         if (ctrl_read_enable || ctrl_write_enable) begin
            if (busy >= ctrl_lat) begin
               ctrl_ready     = 1'b1;
               ctrl_read_data = ovr_en ? ovr_dat : (32'hC0DE_0000 | ctrl_address);
               busy           = 0;
            end else begin
               ctrl_ready     = 1'b0;
               ctrl_read_data = 32'h1234_5678;
               busy++;
            end
         end else begin
            ctrl_ready     = 1'b0;
            ctrl_read_data = 32'h1234_5678;
            busy           = 0;
         end
      end
   end

   // Monitor: every completion seen on a requesting port is matched against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if ((p_re[p] | p_we[p]) && (p == 0 ? req0_ready : req1_ready)) begin
               done_cnt[p]++;
               chk("sb_expected_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk($sformatf("sb_port_p%0d", p), p, e.port);
                  chk($sformatf("sb_grant_p%0d", p), grant, e.port);
                  chk($sformatf("sb_addr_p%0d", p), ctrl_address, e.addr);
                  if (e.is_read) begin
                     chk($sformatf("sb_rdata_p%0d", p), p == 0 ? req0_read_data : req1_read_data, e.rdata);
                  end
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int p, input logic re, input logic we,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      p_re[p]   = re;
      p_we[p]   = we;
      p_addr[p] = a;
      p_wd[p]   = d;
   endtask

   task automatic drop(input int p);
      p_re[p] = 1'b0;
      p_we[p] = 1'b0;
   endtask

   task automatic push(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit rd);
      exp_t e;
      e.port = p; e.addr = a; e.rdata = d; e.is_read = rd;
      exp_q.push_back(e);
   endtask

   // Waits for the port's next completion, drops its request, returns enabled-cycle count.
   task automatic wait_done(input int p, input int bound, output int en_cyc);
      int start;
      start  = done_cnt[p];
      en_cyc = 0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (done_cnt[p] != start) begin
            drop(p);
            return;
         end
         if (ctrl_read_enable || ctrl_write_enable) en_cyc++;
      end
      chk($sformatf("wait_bound_p%0d", p), done_cnt[p] - start, 1);
      drop(p);
   endtask

   int stable, rdy_hi, rdy_lo, en_cyc, start0, start1, err_at_fire;
   bit fin;

   initial begin
      p_re = '0; p_we = '0;
      p_addr[0] = '0; p_addr[1] = '0; p_wd[0] = '0; p_wd[1] = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      tick();

      // Reset state
      chk("rst_ctrl_en", {ctrl_read_enable, ctrl_write_enable}, 0);
      chk("rst_ctrl_addr", ctrl_address, 0);
      chk("rst_ctrl_wdata", ctrl_write_data, 0);
      chk("rst_ready", {req1_ready, req0_ready}, 2'b11);
      chk("rst_grant", grant, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_hold", {req1_read_data, req0_read_data}, 0);

      // Port 0 write, 5 wait cycles
      ctrl_lat = 5;
      push(0, 12, 0, 0);
      issue(0, 1'b0, 1'b1, 12, 31);
      stable = 0; rdy_hi = 0; fin = 0; start0 = done_cnt[0];
      for (int i = 0; i < 20 && !fin; i++) begin
         tick();
         if (done_cnt[0] != start0) begin
            chk("wr_en_after_done", {ctrl_read_enable, ctrl_write_enable}, 0);
            fin = 1;
            drop(0);
         end else begin
            if (ctrl_write_enable && ctrl_address == 12 && ctrl_write_data == 31) stable++;
            if (req0_ready) rdy_hi++;
         end
      end
      chk("wr_completed", fin, 1);
      chk("wr_stable_cycles", stable, 6);
      chk("wr_ready_cycles", rdy_hi, 1);
      tick();

      // Port 1 read returning DEADBEEF; port 0 idle must stay ready
      ctrl_lat = 3; ovr_en = 1; ovr_dat = 32'hDEAD_BEEF;
      push(1, 15, 32'hDEAD_BEEF, 1);
      issue(1, 1'b1, 1'b0, 15, 0);
      rdy_lo = 0; fin = 0; start1 = done_cnt[1];
      for (int i = 0; i < 20 && !fin; i++) begin
         tick();
         if (!req0_ready) rdy_lo++;
         if (done_cnt[1] != start1) begin
            fin = 1;
            drop(1);
         end
      end
      chk("p1_rd_completed", fin, 1);
      chk("p1_rd_p0_ready_low_cycles", rdy_lo, 0);
      ovr_en = 0;
      tick(); tick();
      chk("p1_rd_hold", req1_read_data, 32'hDEAD_BEEF);
      chk("p1_rd_grant_after", grant, 1);

      // Simultaneous reads, both held for four completions
      ctrl_lat = 2;
`ifdef ARB_ROUND_ROBIN_EN
      push(0, 15, 32'hC0DE_000F, 1); push(1, 20, 32'hC0DE_0014, 1);
      push(0, 15, 32'hC0DE_000F, 1); push(1, 20, 32'hC0DE_0014, 1);
`else
      for (int i = 0; i < 4; i++) push(0, 15, 32'hC0DE_000F, 1);
`endif
      start0 = done_cnt[0]; start1 = done_cnt[1];
      issue(0, 1'b1, 1'b0, 15, 0);
      issue(1, 1'b1, 1'b0, 20, 0);
      for (int i = 0; i < 100; i++) begin
         tick();
         if ((done_cnt[0] - start0) + (done_cnt[1] - start1) >= 4) break;
      end
      drop(0); drop(1);
      chk("tie_rounds", (done_cnt[0] - start0) + (done_cnt[1] - start1), 4);
`ifdef ARB_ROUND_ROBIN_EN
      chk("tie_port1_grants", done_cnt[1] - start1, 2);
`else
      chk("tie_port1_grants", done_cnt[1] - start1, 0);
`endif
      tick(); tick();
      chk("tie_no_extra_grant", {ctrl_read_enable, ctrl_write_enable}, 0);
      chk("tie_hold0", req0_read_data, 32'hC0DE_000F);
`ifdef ARB_ROUND_ROBIN_EN
      chk("tie_hold1", req1_read_data, 32'hC0DE_0014);
`else
      chk("tie_hold1", req1_read_data, 32'hDEAD_BEEF);
`endif

      // Watchdog: controller never completes
      ctrl_lat = 100000;
      push(0, 40, 0, 1);
      issue(0, 1'b1, 1'b0, 40, 0);
      en_cyc = 0; fin = 0; err_at_fire = -1; start0 = done_cnt[0];
      for (int i = 0; i < 400 && !fin; i++) begin
         tick();
         if (done_cnt[0] != start0) begin
            fin = 1;
            chk("tmo_err_set", err_timeout, 1);
            chk("tmo_idle_en", {ctrl_read_enable, ctrl_write_enable}, 0);
            drop(0);
         end else begin
            if (ctrl_read_enable) en_cyc++;
            err_at_fire = int'(err_timeout);
         end
      end
      chk("tmo_fired", fin, 1);
      chk("tmo_grant_cycles", en_cyc, 256);
      chk("tmo_err_before", err_at_fire, 0);
      repeat (5) tick();
      chk("tmo_err_sticky", err_timeout, 1);
      chk("tmo_hold_zero", req0_read_data, 0);

      // Reset mid-grant, then the held request is re-issued
      ctrl_lat = 6;
      push(1, 8, 0, 0);
      issue(1, 1'b0, 1'b1, 8, 32'h55);
      repeat (3) tick();
      chk("mid_rst_granted", ctrl_write_enable, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_en_drop", {ctrl_read_enable, ctrl_write_enable}, 0);
      chk("mid_rst_ready_low", req1_ready, 0);
      chk("mid_rst_err_clear", err_timeout, 0);
      tick(); tick();
      rst = 1'b1;
      wait_done(1, 50, en_cyc);
      chk("reissue_en_cycles", en_cyc, 7);
      tick(); tick();

      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
